// File: rtl/stratixv_lvds_loaden_gen.sv
// Per-channel load-enable generator: divides clkin by a runtime ratio and pulses lloaden at a programmed phase.
// Latency: lloaden/clkdiv_out are registered and track the counter value of the same cycle; new ratios apply on the channel's wrap edge.
// Backpressure: cfg_ready drops for a channel while its shadow config waits to be applied. Optional clkdiv_out via STRATIXV_LOADEN_CLKOUT_EN.
module stratixv_lvds_loaden_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 5,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                       clkin,
  input  logic                       clrn,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]           cfg_div,
  input  logic [CNT_W-1:0]           cfg_phase,
  input  logic                       sync_req,
  output logic [NUM_CH-1:0]          lloaden,
  output logic [NUM_CH-1:0]          clkdiv_out,
  output logic                       aligned
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] PH_RST  = CNT_W'(DEFAULT_DIV - 1);

  // Active and shadow per-channel state
  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  div_q    [NUM_CH];
  logic [CNT_W-1:0]  phase_q  [NUM_CH];
  logic [CNT_W-1:0]  sh_div   [NUM_CH];
  logic [CNT_W-1:0]  sh_phase [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] ld_q;
  logic              aligned_q;

  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_d      [NUM_CH];
  logic [CNT_W-1:0]  phase_d    [NUM_CH];
  logic [CNT_W-1:0]  sh_div_d   [NUM_CH];
  logic [CNT_W-1:0]  sh_phase_d [NUM_CH];
  logic [NUM_CH-1:0] pending_d;
  logic [NUM_CH-1:0] ld_d;
  logic [NUM_CH-1:0] wrap;
  logic              applied_any;
  logic              aligned_d;
  logic              accept;

  // A phase at or beyond the terminal count collapses onto the terminal count
  function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] d,
                                                   input logic [CNT_W-1:0] p);
    if (d == '0)     return '0;
    else if (p >= d) return d - CNT_W'(1);
    else             return p;
  endfunction

  // Out-of-range channel numbers (non power-of-two NUM_CH) are never ready
  assign cfg_ready = (32'(cfg_ch) < NUM_CH) ? !pending[cfg_ch] : 1'b0;
  assign accept    = cfg_valid && cfg_ready;

  // Next-state for counters, active/shadow config, pulses and alignment flag
  always_comb begin
    applied_any = 1'b0;
    aligned_d   = aligned_q;
    pending_d   = pending;
    wrap        = '0;
    ld_d        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]      = cnt[i];
      div_d[i]      = div_q[i];
      phase_d[i]    = phase_q[i];
      sh_div_d[i]   = sh_div[i];
      sh_phase_d[i] = sh_phase[i];
      wrap[i]       = (div_q[i] != '0) && (cnt[i] == div_q[i] - CNT_W'(1));

      if (sync_req) begin
        // Sync restarts everyone and flushes waiting configs right now
        cnt_d[i] = '0;
        if (pending[i]) begin
          div_d[i]     = sh_div[i];
          phase_d[i]   = clamp_phase(sh_div[i], sh_phase[i]);
          pending_d[i] = 1'b0;
        end
      end else if (pending[i] && ((div_q[i] <= CNT_W'(1)) || wrap[i])) begin
        // Swap on the period boundary so no runt period is produced
        cnt_d[i]     = '0;
        div_d[i]     = sh_div[i];
        phase_d[i]   = clamp_phase(sh_div[i], sh_phase[i]);
        pending_d[i] = 1'b0;
        applied_any  = 1'b1;
      end else if ((div_q[i] == '0) || wrap[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt[i] + CNT_W'(1);
      end

      // A config accepted alongside a sync lands after the flush and stays pending
      if (accept && (cfg_ch == CH_W'(i))) begin
        sh_div_d[i]   = cfg_div;
        sh_phase_d[i] = cfg_phase;
        pending_d[i]  = 1'b1;
      end

      ld_d[i] = (div_d[i] != '0) && (cnt_d[i] == phase_d[i]);
    end

    if (sync_req)         aligned_d = 1'b0;
    else if (applied_any) aligned_d = 1'b0;
    else if (wrap[0])     aligned_d = 1'b1;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        div_q[i]    <= DIV_RST;
        phase_q[i]  <= PH_RST;
        sh_div[i]   <= DIV_RST;
        sh_phase[i] <= PH_RST;
      end
      pending   <= '0;
      ld_q      <= '0;
      aligned_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= cnt_d[i];
        div_q[i]    <= div_d[i];
        phase_q[i]  <= phase_d[i];
        sh_div[i]   <= sh_div_d[i];
        sh_phase[i] <= sh_phase_d[i];
      end
      pending   <= pending_d;
      ld_q      <= ld_d;
      aligned_q <= aligned_d;
    end
  end

  assign lloaden = ld_q;
  assign aligned = aligned_q;

`ifdef STRATIXV_LOADEN_CLKOUT_EN
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;

  // Divided clock is high for the first ceil(D/2) counts; odd ratios favour high
  always_comb begin
    clk_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clk_d[i] = (div_d[i] != '0) &&
                 ({1'b0, cnt_d[i]} < (({1'b0, div_d[i]} + (CNT_W+1)'(1)) >> 1));
    end
  end

  // Divided clock register
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) clk_q <= '0;
    else       clk_q <= clk_d;
  end

  assign clkdiv_out = clk_q;
`else
  assign clkdiv_out = '0;
`endif

endmodule

// File: tb/tb_stratixv_lvds_loaden_gen.sv
// Directed bench for stratixv_lvds_loaden_gen: table of per-edge vectors plus sync, degenerate and async-reset sequences.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: cfg_ready checked on the channel currently presented on cfg_ch.
module tb_stratixv_lvds_loaden_gen;

  logic       clkin     = 1'b0;
  logic       clrn      = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch    = 2'd0;
  logic [4:0] cfg_div   = 5'd0;
  logic [4:0] cfg_phase = 5'd0;
  logic       sync_req  = 1'b0;
  logic       cfg_ready;
  logic [3:0] lloaden;
  logic [3:0] clkdiv_out;
  logic       aligned;

`ifdef STRATIXV_LOADEN_CLKOUT_EN
  localparam bit CLK_EN = 1'b1;
`else
  localparam bit CLK_EN = 1'b0;
`endif

  stratixv_lvds_loaden_gen #(.NUM_CH(4), .CNT_W(5), .DEFAULT_DIV(4)) dut (
    .clkin      (clkin),
    .clrn       (clrn),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_phase  (cfg_phase),
    .sync_req   (sync_req),
    .lloaden    (lloaden),
    .clkdiv_out (clkdiv_out),
    .aligned    (aligned)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic       v;
    logic [1:0] ch;
    logic [4:0] dv;
    logic [4:0] ph;
    logic       s;
    logic [3:0] exp_ld;
    logic       exp_rdy;
    logic       exp_al;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] ch, input logic [4:0] dv,
                     input logic [4:0] ph, input logic s, input logic [3:0] ld,
                     input logic rdy, input logic al);
    vec_t r;
    r.v = v; r.ch = ch; r.dv = dv; r.ph = ph; r.s = s;
    r.exp_ld = ld; r.exp_rdy = rdy; r.exp_al = al;
    tbl.push_back(r);
  endtask

  // Drive inputs, take one rising edge, then settle away from the edge
  task automatic step(input logic v, input logic [1:0] ch, input logic [4:0] dv,
                      input logic [4:0] ph, input logic s);
    cfg_valid = v; cfg_ch = ch; cfg_div = dv; cfg_phase = ph; sync_req = s;
    @(posedge clkin);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         dv[4];
    int         ph[4];
    logic [3:0] eld;
    logic [3:0] eclk;

    // Edges 1..13: default ratio 4, phase 3, pulses on edges 3,7,11; aligned from edge 4
    for (int e = 1; e <= 13; e++)
      add(1'b0, 2'd0, 5'd0, 5'd0, 1'b0, (e % 4 == 3) ? 4'hF : 4'h0, 1'b1, (e >= 4));
    // Reprogram ch1 to div5/phase2 while its counter is 1
    add(1'b1, 2'd1, 5'd5, 5'd2, 1'b0, 4'b0000, 1'b0, 1'b1);  // 14 accept, cnt=2
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b1111, 1'b0, 1'b1);  // 15 old period finishes
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);  // 16 apply edge
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);  // 17
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b0);  // 18 ch1 cnt=2
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b1101, 1'b1, 1'b0);  // 19
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 20 ch0 wrap re-aligns
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 21
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 22
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b1111, 1'b1, 1'b1);  // 23
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 24
    // Clamp (div3/phase7) then a refused config while pending
    add(1'b1, 2'd1, 5'd3, 5'd7, 1'b0, 4'b0000, 1'b0, 1'b1);  // 25 accept
    add(1'b1, 2'd1, 5'd1, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);  // 26 refused, ch1 applies
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b1101, 1'b1, 1'b0);  // 27
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b1);  // 28 clamped pulse at 2
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 29
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1);  // 30
    add(1'b0, 2'd1, 5'd0, 5'd0, 1'b0, 4'b1111, 1'b1, 1'b1);  // 31

    // Reset state
    #2 clrn = 1'b0;
    #2;
    chk("reset_lloaden", 32'(lloaden), 32'h0);
    chk("reset_aligned", 32'(aligned), 32'h0);
    chk("reset_ready", 32'(cfg_ready), 32'h1);
    chk("reset_clkdiv", 32'(clkdiv_out), 32'h0);
    @(posedge clkin);
    #1 clrn = 1'b1;

    foreach (tbl[n]) begin
      step(tbl[n].v, tbl[n].ch, tbl[n].dv, tbl[n].ph, tbl[n].s);
      chk($sformatf("row%0d_lloaden", n + 1), 32'(lloaden), 32'(tbl[n].exp_ld));
      chk($sformatf("row%0d_ready", n + 1), 32'(cfg_ready), 32'(tbl[n].exp_rdy));
      chk($sformatf("row%0d_aligned", n + 1), 32'(aligned), 32'(tbl[n].exp_al));
    end

    // Sync: program 3/4/5/6 with phases 1..4, ch3 still pending when sync hits
    dv = '{3, 4, 5, 6};
    ph = '{1, 2, 3, 4};
    step(1'b1, 2'd0, 5'd3, 5'd1, 1'b0);
    step(1'b1, 2'd1, 5'd4, 5'd2, 1'b0);
    step(1'b1, 2'd2, 5'd5, 5'd3, 1'b0);
    for (int j = 0; j < 8; j++) step(1'b0, 2'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 2'd3, 5'd6, 5'd4, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 2'd3, 5'd0, 5'd0, (k == 0));
      for (int i = 0; i < 4; i++) begin
        eld[i]  = ((k % dv[i]) == ph[i]);
        eclk[i] = CLK_EN && ((k % dv[i]) < (dv[i] + 1) / 2);
      end
      chk($sformatf("sync_k%0d_lloaden", k), 32'(lloaden), 32'(eld));
      chk($sformatf("sync_k%0d_aligned", k), 32'(aligned), 32'(k >= 3));
      chk($sformatf("sync_k%0d_clkdiv", k), 32'(clkdiv_out), 32'(eclk));
    end
    chk("sync_ready_ch3", 32'(cfg_ready), 32'h1);

    // Degenerate ratios: ch2 disabled, ch3 divide-by-one
    step(1'b1, 2'd2, 5'd0, 5'd0, 1'b0);
    step(1'b1, 2'd3, 5'd1, 5'd0, 1'b0);
    for (int j = 0; j < 8; j++) step(1'b0, 2'd0, 5'd0, 5'd0, 1'b0);
    for (int j = 0; j < 6; j++) begin
      step(1'b0, 2'd0, 5'd0, 5'd0, 1'b0);
      chk($sformatf("div0_lloaden_c%0d", j), 32'(lloaden[2]), 32'h0);
      chk($sformatf("div1_lloaden_c%0d", j), 32'(lloaden[3]), 32'h1);
      chk($sformatf("div0_clkdiv_c%0d", j), 32'(clkdiv_out[2]), 32'h0);
      chk($sformatf("div1_clkdiv_c%0d", j), 32'(clkdiv_out[3]), 32'(CLK_EN));
    end

    // Async reset between edges with a config pending on ch1
    step(1'b1, 2'd1, 5'd7, 5'd3, 1'b0);
    cfg_valid = 1'b0;
    chk("prereset_ready_ch1", 32'(cfg_ready), 32'h0);
    #2 clrn = 1'b0;
    #1;
    chk("async_lloaden", 32'(lloaden), 32'h0);
    chk("async_aligned", 32'(aligned), 32'h0);
    chk("async_clkdiv", 32'(clkdiv_out), 32'h0);
    chk("async_ready_ch1", 32'(cfg_ready), 32'h1);
    @(posedge clkin);
    #1 clrn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 2'd1, 5'd0, 5'd0, 1'b0);
      chk($sformatf("rel_e%0d_lloaden", e), 32'(lloaden), (e % 4 == 3) ? 32'hF : 32'h0);
      chk($sformatf("rel_e%0d_aligned", e), 32'(aligned), 32'(e >= 4));
      chk($sformatf("rel_e%0d_clkdiv", e), 32'(clkdiv_out),
          (CLK_EN && (e % 4 < 2)) ? 32'hF : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
